// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: fetch stage; owns the PC, issues imem word requests,
// queues returned words in order and hands {instr, pc} to decode.
// Ports: i_clk, i_rst_n | imem: o_imem_req/o_imem_addr/i_imem_ready,
//   i_imem_rvalid/i_imem_rdata | i_redirect/i_redirect_pc |
//   decode: o_valid/o_instr/o_pc/i_ready
module instr_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ready,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  input  logic        i_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0]   LIM = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [31:0]   NOP = 32'h0000_0013;

  typedef enum logic {
    S_RUN,
    S_DRAIN
  } state_t;

  state_t        r_state;
  state_t        w_state_nx;
  logic [31:0]   r_pc;
  logic [31:0]   r_rpc;
  logic [31:0]   r_instr [DEPTH];
  logic [31:0]   r_epc   [DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_out;
  logic [CW-1:0] r_drop;
  logic [CW-1:0] w_drop_nx;
  logic [CW-1:0] w_out_dec;
  logic [31:0]   w_rdpc;
  logic          w_credit;
  logic          w_issue;
  logic          w_keep;
  logic          w_pop;
  logic          w_unused;

  // Outstanding already includes words still to be dropped,
  // so the credit check covers them without extra terms.
  assign w_credit  = ({1'b0, r_cnt} + {1'b0, r_out}) < LIM;
  assign o_imem_req  = i_rst_n & ~i_redirect & w_credit;
  assign o_imem_addr = r_pc;
  assign w_issue   = o_imem_req & i_imem_ready;

  assign w_keep = i_imem_rvalid & ~i_redirect
                & (r_state == S_RUN);
  assign w_pop  = o_valid & i_ready & ~i_redirect;

  assign o_valid = (r_cnt != '0);
  assign o_instr = r_instr[r_rd];
  assign o_pc    = r_epc[r_rd];

  assign w_out_dec = r_out - CW'(i_imem_rvalid);
  assign w_rdpc    = {i_redirect_pc[31:2], 2'b00};
  assign w_unused  = &{1'b0, i_redirect_pc[1:0]};

  // DRAIN holds exactly while stale responses remain to be dropped.
  always_comb begin
    w_state_nx = r_state;
    w_drop_nx  = r_drop;
    if (i_redirect) begin
      w_drop_nx  = w_out_dec;
      w_state_nx = (w_out_dec != '0) ? S_DRAIN : S_RUN;
    end else begin
      unique case (r_state)
        S_RUN: begin
          w_state_nx = S_RUN;
        end
        S_DRAIN: begin
          if (i_imem_rvalid) begin
            w_drop_nx = r_drop - ONE;
            if (r_drop == ONE) w_state_nx = S_RUN;
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_RUN;
      r_pc    <= RESET_PC;
      r_rpc   <= RESET_PC;
      r_wr    <= '0;
      r_rd    <= '0;
      r_cnt   <= '0;
      r_out   <= '0;
      r_drop  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_instr[i] <= NOP;
        r_epc[i]   <= '0;
      end
    end else begin
      r_state <= w_state_nx;
      r_drop  <= w_drop_nx;
      r_out   <= w_out_dec + CW'(w_issue);
      if (i_redirect) begin
        r_pc  <= w_rdpc;
        r_rpc <= w_rdpc;
        r_cnt <= '0;
        r_rd  <= r_wr;
      end else begin
        if (w_issue) r_pc <= r_pc + 32'd4;
        if (w_keep) begin
          r_instr[r_wr] <= i_imem_rdata;
          r_epc[r_wr]   <= r_rpc;
          r_wr          <= r_wr + PW'(1);
          r_rpc         <= r_rpc + 32'd4;
        end
        if (w_pop) r_rd <= r_rd + PW'(1);
        r_cnt <= r_cnt + CW'(w_keep) - CW'(w_pop);
      end
    end
  end

  a_rsp_credit: assert property (
    @(posedge i_clk) disable iff (!i_rst_n)
    i_imem_rvalid |-> (r_out != '0)
  );

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: directed bench for instr_fetch_queue with an
// in-order memory model returning 0x13 + addr.
module tb_instr_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ready;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_valid;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic        i_ready;

  logic        x_req;
  logic [31:0] x_addr;
  logic        x_valid;
  logic [31:0] x_instr;
  logic [31:0] x_pc;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_iss   = 0;
  logic [31:0] mq[$];
  logic        mem_en;

  always #5 clk = ~clk;

  instr_fetch_queue #(
    .RESET_PC(32'h0000_0000),
    .DEPTH   (2)
  ) u_dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .o_imem_req   (o_imem_req),
    .o_imem_addr  (o_imem_addr),
    .i_imem_ready (i_imem_ready),
    .i_imem_rvalid(i_imem_rvalid),
    .i_imem_rdata (i_imem_rdata),
    .i_redirect   (i_redirect),
    .i_redirect_pc(i_redirect_pc),
    .o_valid      (o_valid),
    .o_instr      (o_instr),
    .o_pc         (o_pc),
    .i_ready      (i_ready)
  );

  instr_fetch_queue #(
    .RESET_PC(32'hFFFF_FFFC),
    .DEPTH   (2)
  ) u_wrap (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .o_imem_req   (x_req),
    .o_imem_addr  (x_addr),
    .i_imem_ready (1'b1),
    .i_imem_rvalid(1'b0),
    .i_imem_rdata (32'h0),
    .i_redirect   (1'b0),
    .i_redirect_pc(32'h0),
    .o_valid      (x_valid),
    .o_instr      (x_instr),
    .o_pc         (x_pc),
    .i_ready      (1'b1)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic        iss;
    logic        rsp;
    logic [31:0] a;
    iss = o_imem_req & i_imem_ready;
    a   = o_imem_addr;
    rsp = i_imem_rvalid;
    @(posedge clk);
    #1;
    if (rsp && mq.size() > 0) mq.delete(0);
    if (iss) begin
      mq.push_back(a);
      n_iss++;
    end
    i_imem_rvalid = mem_en && (mq.size() > 0);
    i_imem_rdata  = i_imem_rvalid ? 32'h13 + mq[0] : 32'h0;
    #1;
  endtask

  initial begin
    rst_n         = 1'b0;
    i_imem_ready  = 1'b1;
    i_imem_rvalid = 1'b0;
    i_imem_rdata  = 32'h0;
    i_redirect    = 1'b0;
    i_redirect_pc = 32'h0;
    i_ready       = 1'b1;
    mem_en        = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", 32'(o_imem_req), 32'd0);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_instr", o_instr, 32'h13);
    chk("rst_pc", o_pc, 32'h0);
    chk("rst_xreq", 32'(x_req), 32'd0);

    rst_n = 1'b1;
    #1;
    chk("t1_req0", 32'(o_imem_req), 32'd1);
    chk("t1_addr0", o_imem_addr, 32'h0);
    chk("t6_xaddr0", x_addr, 32'hFFFF_FFFC);
    tick();
    chk("t1_valid_c2", 32'(o_valid), 32'd0);
    chk("t1_addr1", o_imem_addr, 32'h4);
    chk("t6_xaddr1", x_addr, 32'h0);
    chk("t6_xreq1", 32'(x_req), 32'd1);
    tick();
    chk("t1_valid_c3", 32'(o_valid), 32'd1);
    chk("t1_pc0", o_pc, 32'h0);
    chk("t1_instr0", o_instr, 32'h13);
    chk("t1_credit", 32'(o_imem_req), 32'd0);
    chk("t6_xcredit", 32'(x_req), 32'd0);
    tick();
    chk("t1_pc1", o_pc, 32'h4);
    chk("t1_instr1", o_instr, 32'h17);
    chk("t1_addr2", o_imem_addr, 32'h8);
    tick();
    chk("t1_addr3", o_imem_addr, 32'hC);

    i_ready = 1'b0;
    n_iss   = 0;
    tick();
    chk("t2_pc", o_pc, 32'h8);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t2_hold_pc", o_pc, 32'h8);
    end
    chk("t2_instr", o_instr, 32'h1B);
    chk("t2_req", 32'(o_imem_req), 32'd0);
    chk("t2_issued", 32'(n_iss), 32'd1);

    i_ready      = 1'b1;
    i_imem_ready = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t3_req", 32'(o_imem_req), 32'd1);
      chk("t3_addr", o_imem_addr, 32'h10);
    end
    chk("t3_valid", 32'(o_valid), 32'd0);

    i_imem_ready = 1'b1;
    mem_en       = 1'b0;
    #1;
    tick();
    tick();
    chk("t4_out2", 32'(o_imem_req), 32'd0);
    i_redirect    = 1'b1;
    i_redirect_pc = 32'h103;
    mem_en        = 1'b1;
    #1;
    chk("t4_redir_req", 32'(o_imem_req), 32'd0);
    tick();
    i_redirect = 1'b0;
    #1;
    chk("t4_valid_a", 32'(o_valid), 32'd0);
    tick();
    chk("t4_valid_b", 32'(o_valid), 32'd0);
    chk("t4_addr", o_imem_addr, 32'h100);
    tick();
    chk("t4_valid_c", 32'(o_valid), 32'd0);
    chk("t4_addr2", o_imem_addr, 32'h104);
    tick();
    chk("t4_valid_d", 32'(o_valid), 32'd1);
    chk("t4_pc0", o_pc, 32'h100);
    chk("t4_instr0", o_instr, 32'h113);
    tick();
    chk("t4_pc1", o_pc, 32'h104);
    chk("t4_instr1", o_instr, 32'h117);

    i_ready = 1'b0;
    #1;
    tick();
    chk("t5_pre_valid", 32'(o_valid), 32'd1);
    chk("t5_pre_rv", 32'(i_imem_rvalid), 32'd1);
    i_ready       = 1'b1;
    i_redirect    = 1'b1;
    i_redirect_pc = 32'h200;
    #1;
    tick();
    i_redirect = 1'b0;
    #1;
    chk("t5_valid", 32'(o_valid), 32'd0);
    chk("t5_addr", o_imem_addr, 32'h200);
    tick();
    tick();
    chk("t5_valid2", 32'(o_valid), 32'd1);
    chk("t5_pc", o_pc, 32'h200);
    chk("t5_instr", o_instr, 32'h213);

    rst_n = 1'b0;
    #1;
    chk("t6_req", 32'(o_imem_req), 32'd0);
    chk("t6_valid", 32'(o_valid), 32'd0);
    chk("t6_instr", o_instr, 32'h13);
    chk("t6_pc", o_pc, 32'h0);
    mq.delete();
    i_imem_rvalid = 1'b0;
    i_imem_rdata  = 32'h0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("t6_req_again", 32'(o_imem_req), 32'd1);
    chk("t6_addr_again", o_imem_addr, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
